// File: rtl/i2c_mon_pkg.sv
// Shared types for the I2C bus monitor: event type codes, the FIFO event record
// and the FIFO level width helper.
package i2c_mon_pkg;

   typedef enum logic [2:0] {
      EVT_START   = 3'd0,
      EVT_RESTART = 3'd1,
      EVT_STOP    = 3'd2,
      EVT_BYTE    = 3'd3
   } evt_type_e;

   typedef struct packed {
      evt_type_e  evt_type;
      logic [7:0] data;
      logic       ack;
   } i2c_evt_t;

   function automatic int FIFO_LEVEL_W(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/i2c_mon_fifo.sv
// Synchronous event FIFO for the I2C monitor. A push while full is accepted only
// when a pop happens in the same cycle; the head entry is presented with no bypass.
module i2c_mon_fifo
   import i2c_mon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  i2c_evt_t                       din,
   input  logic                           pop,
   output i2c_evt_t                       dout,
   output logic                           full,
   output logic                           empty,
   output logic [FIFO_LEVEL_W(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = FIFO_LEVEL_W(DEPTH);

   i2c_evt_t        mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [LW-1:0]   count_r;
   logic            do_pop_s;
   logic            do_push_s;

   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + LW'(1);
            2'b01:   count_r <= count_r - LW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign full  = (count_r == LW'(DEPTH));
   assign empty = (count_r == LW'(0));
   assign dout  = mem_r[rd_ptr_r];
   assign level = count_r;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronise + deglitch SCL/SDA, detect START/RESTART/STOP,
// assemble bytes with ACK, queue typed events. Define I2C_MON_ADDR_FILTER_EN for addr_i.
module i2c_bus_monitor
   import i2c_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
`ifdef I2C_MON_ADDR_FILTER_EN
   input  logic [6:0]                          addr_i,
`endif
   input  logic                                scl_i,
   input  logic                                sda_i,
   input  logic                                evt_ready_i,
   input  logic                                ovf_clr_i,
   output logic                                evt_valid_o,
   output logic [2:0]                          evt_type_o,
   output logic [7:0]                          evt_data_o,
   output logic                                evt_ack_o,
   output logic                                busy_o,
   output logic                                overflow_o,
   output logic [FIFO_LEVEL_W(FIFO_DEPTH)-1:0] fifo_level_o
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;

   // Line index 0 is SCL, 1 is SDA.
   logic [1:0]             raw_s;
   logic [SYNC_STAGES-1:0] sync_r    [2];
   logic [CNT_W-1:0]       flt_cnt_r [2];
   logic [1:0]             filt_r;
   logic [1:0]             filt_d_r;

   logic scl_f_s, sda_f_s, scl_d_s, sda_d_s;
   logic start_det_s, stop_det_s, scl_rise_s, scl_fall_s;

   logic       busy_r, busy_n;
   logic [3:0] bit_cnt_r, bit_cnt_n;
   logic [7:0] shift_r, shift_n;
   logic       pend_r, pend_n;
   logic       pend_bit_r, pend_bit_n;
   logic       evt_push_r, evt_push_n;
   i2c_evt_t   evt_r, evt_n;
`ifdef I2C_MON_ADDR_FILTER_EN
   logic       first_r, first_n;
   logic       supp_r, supp_n;
`endif

   i2c_evt_t   head_s;
   logic       fifo_full_s, fifo_empty_s, pop_s, drop_s;
   logic       overflow_r;

   assign raw_s = {sda_i, scl_i};

   // Input synchronisers and run-length glitch filters, reset to the idle-high bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2; i++) begin
            sync_r[i]    <= '1;
            flt_cnt_r[i] <= '0;
         end
         filt_r   <= 2'b11;
         filt_d_r <= 2'b11;
      end else begin
         for (int i = 0; i < 2; i++) begin
            sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
            if (sync_r[i][SYNC_STAGES-1] != filt_r[i]) begin
               if (flt_cnt_r[i] == CNT_W'(FILTER_LEN - 1)) begin
                  filt_r[i]    <= sync_r[i][SYNC_STAGES-1];
                  flt_cnt_r[i] <= '0;
               end else begin
                  flt_cnt_r[i] <= flt_cnt_r[i] + CNT_W'(1);
               end
            end else begin
               flt_cnt_r[i] <= '0;
            end
         end
         filt_d_r <= filt_r;
      end
   end

   assign scl_f_s = filt_r[0];
   assign sda_f_s = filt_r[1];
   assign scl_d_s = filt_d_r[0];
   assign sda_d_s = filt_d_r[1];

   // SCL steady high in both cycles excludes a simultaneous SCL edge.
   assign start_det_s = scl_f_s & scl_d_s & sda_d_s & ~sda_f_s;
   assign stop_det_s  = scl_f_s & scl_d_s & ~sda_d_s & sda_f_s;
   assign scl_rise_s  = scl_f_s & ~scl_d_s;
   assign scl_fall_s  = ~scl_f_s & scl_d_s;

   // Bus state: SDA is sampled on SCL rise (previous-cycle SDA) and committed on the
   // following fall, so the SCL rise that precedes a STOP/RESTART is not counted.
   always_comb begin
      busy_n     = busy_r;
      bit_cnt_n  = bit_cnt_r;
      shift_n    = shift_r;
      pend_n     = pend_r;
      pend_bit_n = pend_bit_r;
      evt_push_n = 1'b0;
      evt_n      = '{evt_type: EVT_START, data: 8'h00, ack: 1'b0};
`ifdef I2C_MON_ADDR_FILTER_EN
      first_n    = first_r;
      supp_n     = supp_r;
`endif
      if (start_det_s) begin
         evt_push_n     = 1'b1;
         evt_n.evt_type = busy_r ? EVT_RESTART : EVT_START;
         evt_n.data     = {4'h0, bit_cnt_r};
         busy_n         = 1'b1;
         bit_cnt_n      = 4'd0;
         pend_n         = 1'b0;
`ifdef I2C_MON_ADDR_FILTER_EN
         first_n        = 1'b1;
         supp_n         = 1'b0;
`endif
      end else if (stop_det_s && busy_r) begin
         evt_push_n     = 1'b1;
         evt_n.evt_type = EVT_STOP;
         evt_n.data     = {4'h0, bit_cnt_r};
         busy_n         = 1'b0;
         bit_cnt_n      = 4'd0;
         pend_n         = 1'b0;
`ifdef I2C_MON_ADDR_FILTER_EN
         first_n        = 1'b0;
         supp_n         = 1'b0;
`endif
      end else if (busy_r && scl_rise_s) begin
         if (bit_cnt_r == 4'd8) begin
            evt_n.evt_type = EVT_BYTE;
            evt_n.data     = shift_r;
            evt_n.ack      = ~sda_d_s;
            bit_cnt_n      = 4'd0;
`ifdef I2C_MON_ADDR_FILTER_EN
            if (supp_r || (first_r && (shift_r[7:1] != addr_i))) begin
               evt_push_n = 1'b0;
               supp_n     = 1'b1;
            end else begin
               evt_push_n = 1'b1;
            end
            first_n = 1'b0;
`else
            evt_push_n = 1'b1;
`endif
         end else begin
            pend_n     = 1'b1;
            pend_bit_n = sda_d_s;
         end
      end else if (busy_r && scl_fall_s && pend_r) begin
         shift_n   = {shift_r[6:0], pend_bit_r};
         bit_cnt_n = bit_cnt_r + 4'd1;
         pend_n    = 1'b0;
      end else begin
         evt_push_n = 1'b0;
      end
   end

   // Bus state and registered event staging.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_r     <= 1'b0;
         bit_cnt_r  <= 4'd0;
         shift_r    <= 8'h00;
         pend_r     <= 1'b0;
         pend_bit_r <= 1'b0;
         evt_push_r <= 1'b0;
         evt_r      <= '0;
`ifdef I2C_MON_ADDR_FILTER_EN
         first_r    <= 1'b0;
         supp_r     <= 1'b0;
`endif
      end else begin
         busy_r     <= busy_n;
         bit_cnt_r  <= bit_cnt_n;
         shift_r    <= shift_n;
         pend_r     <= pend_n;
         pend_bit_r <= pend_bit_n;
         evt_push_r <= evt_push_n;
         evt_r      <= evt_n;
`ifdef I2C_MON_ADDR_FILTER_EN
         first_r    <= first_n;
         supp_r     <= supp_n;
`endif
      end
   end

   assign pop_s  = evt_valid_o & evt_ready_i;
   assign drop_s = evt_push_r & fifo_full_s & ~pop_s;

   // Sticky overflow; a drop wins over a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr_i) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   i2c_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (evt_push_r),
      .din   (evt_r),
      .pop   (pop_s),
      .dout  (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_o)
   );

   assign evt_valid_o = ~fifo_empty_s;
   assign evt_type_o  = head_s.evt_type;
   assign evt_data_o  = head_s.data;
   assign evt_ack_o   = head_s.ack;
   assign busy_o      = busy_r;
   assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: a bench-side I2C master drives the bus while a
// transaction-level event model feeds a scoreboard checked on every accepted event.
module tb_i2c_bus_monitor;
   import i2c_mon_pkg::*;

   localparam int SYNC  = 2;
   localparam int FLT   = 3;
   localparam int DEPTH = 4;
   localparam int Q     = 20;
   localparam int LAT   = SYNC + FLT + 2;

   logic       clk = 1'b0;
   logic       rst, scl, sda, ready, ovf_clr;
   logic       evt_valid, evt_ack, busy, overflow;
   logic [2:0] evt_type;
   logic [7:0] evt_data;
   logic [2:0] fifo_level;
`ifdef I2C_MON_ADDR_FILTER_EN
   logic [6:0] addr = 7'h7D;
`endif

   i2c_bus_monitor #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
`ifdef I2C_MON_ADDR_FILTER_EN
      .addr_i       (addr),
`endif
      .scl_i        (scl),
      .sda_i        (sda),
      .evt_ready_i  (ready),
      .ovf_clr_i    (ovf_clr),
      .evt_valid_o  (evt_valid),
      .evt_type_o   (evt_type),
      .evt_data_o   (evt_data),
      .evt_ack_o    (evt_ack),
      .busy_o       (busy),
      .overflow_o   (overflow),
      .fifo_level_o (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int d;
      int a;
   } ev_t;

   ev_t exp_q[$];
   ev_t log_q[$];
   int  n_pass = 0;
   int  n_total = 0;
   bit  m_busy = 1'b0;
   int  m_bits = 0;
   bit  hold_mode = 1'b0;
   int  held = 0;
   bit  m_ovf = 1'b0;
   bit  m_first = 1'b0;
   bit  m_supp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // With the consumer stalled only the first DEPTH events can be held.
   task automatic model_push(input int t, input int d, input int a);
      ev_t e;
      e.t = t; e.d = d; e.a = a;
      if (!hold_mode) exp_q.push_back(e);
      else if (held < DEPTH) begin exp_q.push_back(e); held++; end
      else m_ovf = 1'b1;
   endtask

   task automatic bus_start(input bit measure);
      int n;
      model_push(m_busy ? 1 : 0, m_bits % 9, 0);
      m_busy = 1'b1; m_bits = 0; m_first = 1'b1; m_supp = 1'b0;
      sda = 1'b1; tick(Q);
      scl = 1'b1; tick(Q);
      sda = 1'b0;
      if (measure) begin
         n = 0;
         while (!evt_valid && n < 50) begin tick(1); n++; end
         check("start_latency", n, LAT);
      end
      tick(Q);
      scl = 1'b0; tick(Q);
      check("busy_after_start", busy, 1);
   endtask

   task automatic send_bit(input bit b);
      sda = b; tick(Q);
      scl = 1'b1; tick(2 * Q);
      scl = 1'b0; tick(Q);
      m_bits++;
   endtask

   task automatic write_byte(input logic [7:0] d, input bit ack);
      if (m_busy) begin
`ifdef I2C_MON_ADDR_FILTER_EN
         if (m_supp || (m_first && d[7:1] != addr)) m_supp = 1'b1;
         else model_push(3, d, ack);
`else
         model_push(3, d, ack);
`endif
         m_first = 1'b0;
      end
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(!ack);
   endtask

   task automatic bus_stop();
      if (m_busy) model_push(2, m_bits % 9, 0);
      m_busy = 1'b0; m_bits = 0; m_first = 1'b0; m_supp = 1'b0;
      sda = 1'b0; tick(Q);
      scl = 1'b1; tick(Q);
      sda = 1'b1; tick(Q);
      check("busy_after_stop", busy, 0);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin tick(1); n++; end
      check({name, "_drained"}, exp_q.size(), 0);
      tick(10);
      check({name, "_idle_valid"}, evt_valid, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_valid"}, evt_valid, 0);
      check({name, "_type"}, evt_type, 0);
      check({name, "_data"}, evt_data, 0);
      check({name, "_ack"}, evt_ack, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_overflow"}, overflow, 0);
      check({name, "_level"}, fifo_level, 0);
   endtask

   // Scoreboard: every accepted head event must match the model's next event.
   always @(negedge clk) begin : cmp
      ev_t e;
      ev_t act;
      if (!rst && evt_valid && ready) begin
         act.t = int'(evt_type); act.d = int'(evt_data); act.a = int'(evt_ack);
         log_q.push_back(act);
         if (exp_q.size() == 0) begin
            check("unexpected_event_type", evt_type, 7);
         end else begin
            e = exp_q.pop_front();
            check("evt_type", evt_type, e.t);
            check("evt_data", evt_data, e.d);
            check("evt_ack", evt_ack, e.a);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; scl = 1'b1; sda = 1'b1; ready = 1'b1; ovf_clr = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(10);

      // Two written bytes framed by START/STOP.
      log_q.delete();
      bus_start(1'b1);
      write_byte(8'hFA, 1'b1);
      write_byte(8'h0C, 1'b1);
      bus_stop();
      wait_drain("s1");
      check("s1_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         check("s1_first_type", log_q[0].t, 0);
         check("s1_byte0", log_q[1].d, 8'hFA);
         check("s1_byte0_ack", log_q[1].a, 1);
         check("s1_byte1", log_q[2].d, 8'h0C);
         check("s1_last_type", log_q[3].t, 2);
         check("s1_stop_data", log_q[3].d, 0);
      end

      // Repeated START and a NACKed byte.
      log_q.delete();
      bus_start(1'b0);
      write_byte(8'hFA, 1'b1);
      bus_start(1'b0);
      write_byte(8'h15, 1'b1);
      write_byte(8'h16, 1'b0);
      bus_stop();
      wait_drain("s2");
`ifdef I2C_MON_ADDR_FILTER_EN
      check("s2_count", log_q.size(), 4);
`else
      check("s2_count", log_q.size(), 6);
      if (log_q.size() == 6) check("s2_nack", log_q[4].a, 0);
`endif
      if (log_q.size() > 2) check("s2_restart_type", log_q[2].t, 1);

      // Glitch one sample shorter than the filter, then one exactly as long.
      tick(10);
      sda = 1'b0; tick(FLT - 1); sda = 1'b1;
      tick(40);
      check("glitch_valid", evt_valid, 0);
      check("glitch_busy", busy, 0);
      model_push(0, 0, 0);
      model_push(2, 0, 0);
      sda = 1'b0; tick(FLT); sda = 1'b1;
      tick(40);
      wait_drain("pulse");
      check("pulse_busy", busy, 0);

      // Stalled consumer: six events into a four-entry FIFO.
      ready = 1'b0; hold_mode = 1'b1; held = 0; m_ovf = 1'b0;
      bus_start(1'b0);
      write_byte(8'hFA, 1'b1);
      write_byte(8'h22, 1'b1);
      write_byte(8'h33, 1'b1);
      write_byte(8'h44, 1'b1);
      bus_stop();
      tick(20);
      check("ovf_level", fifo_level, 4);
      check("ovf_flag", overflow, 1);
      check("ovf_model", overflow, m_ovf);
      hold_mode = 1'b0; ready = 1'b1;
      wait_drain("ovf");
      check("ovf_sticky", overflow, 1);
      ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
      check("ovf_cleared", overflow, 0);

      // STOP after five data bits reports the aborted bit count.
      log_q.delete();
      bus_start(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      bus_stop();
      wait_drain("partial");
      check("partial_count", log_q.size(), 2);
      if (log_q.size() == 2) check("partial_stop_data", log_q[1].d, 5);

      // Reset in the middle of a byte with an event still queued.
      ready = 1'b0;
      bus_start(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      check("pre_reset_valid", evt_valid, 1);
      rst = 1'b1; #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      m_busy = 1'b0; m_bits = 0; m_first = 1'b0; m_supp = 1'b0;
      tick(3);
      rst = 1'b0; ready = 1'b1;
      tick(5);
      for (int i = 0; i < 4; i++) send_bit(i[1]);
      bus_stop();
      tick(20);
      check("post_reset_no_event", evt_valid, 0);
      log_q.delete();
      bus_start(1'b0);
      write_byte(8'hFA, 1'b0);
      bus_stop();
      wait_drain("post_reset");
      check("post_reset_count", log_q.size(), 3);

`ifdef I2C_MON_ADDR_FILTER_EN
      // Matching and non-matching address transactions.
      log_q.delete();
      bus_start(1'b0);
      write_byte(8'hFA, 1'b1);
      bus_stop();
      bus_start(1'b0);
      write_byte(8'hA0, 1'b1);
      write_byte(8'h55, 1'b1);
      bus_stop();
      wait_drain("addr");
      check("addr_count", log_q.size(), 5);
      if (log_q.size() == 5) check("addr_second_start_then_stop", log_q[4].t, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
